// File: rtl/timer_unit_multi.sv
// timer_unit_multi
//   One WIDTH-bit counter shared by NUM_CH output-compare channels, with a
//   synchronous clock-enable prescaler, double-buffered compare values,
//   normal / CTC / fast PWM / phase-correct PWM modes, a software counter
//   write port and write-1-to-clear flags. All outputs are registered.
//
// Ports
//   clk         timer clock, all state on rising edge
//   reset       asynchronous active-low reset
//   cs          clock select: 0 stop, 1 /1, 2 /8, 3 /64, 4 /256, 5 /1024, 6-7 stop
//   wgm         mode: 0 normal, 1 PC TOP=MAX, 2 CTC, 3 fast TOP=MAX,
//               5 PC TOP=ocr0, 7 fast TOP=ocr0, 4/6 reserved (hold)
//   com         compare output mode per channel (bits 2i+1:2i)
//   ocr         software compare values, channel i at [i*WIDTH +: WIDTH]
//   tcnt_we     counter write strobe
//   tcnt_wdata  counter write value
//   flag_clr    write-1-to-clear: bit0 TOV, bit i+1 OCF channel i
//   tcnt        counter value
//   flags       bit0 TOV, bit i+1 OCF channel i
//   oc          compare output pins
//   dir         count direction (1 = down, phase-correct only)
//   tick        registered copy of the internal count enable
module timer_unit_multi #(
  parameter int WIDTH   = 8,
  parameter int NUM_CH  = 2,
  parameter int PRESC_W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              cs,
  input  logic [2:0]              wgm,
  input  logic [2*NUM_CH-1:0]     com,
  input  logic [NUM_CH*WIDTH-1:0] ocr,
  input  logic                    tcnt_we,
  input  logic [WIDTH-1:0]        tcnt_wdata,
  input  logic [NUM_CH:0]         flag_clr,
  output logic [WIDTH-1:0]        tcnt,
  output logic [NUM_CH:0]         flags,
  output logic [NUM_CH-1:0]       oc,
  output logic                    dir,
  output logic                    tick
);

  localparam logic [WIDTH-1:0] MAX = '1;

  typedef enum logic [2:0] {
    MODE_NORMAL,
    MODE_CTC,
    MODE_FAST,
    MODE_PHASE,
    MODE_RSVD
  } mode_t;

  mode_t              mode;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   ocr_buf [NUM_CH];
  logic [WIDTH-1:0]   top;
  logic               ocr_top;
  logic               en;
  logic               step;
  logic               wrap;
  logic               tov_set;
  logic               buf_load;
  logic [WIDTH-1:0]   tcnt_nx;
  logic               dir_nx;
  logic [NUM_CH-1:0]  match;
  logic [NUM_CH-1:0]  oc_nx;

  always_comb begin
    case (wgm)
      3'd0:       mode = MODE_NORMAL;
      3'd1, 3'd5: mode = MODE_PHASE;
      3'd2:       mode = MODE_CTC;
      3'd3, 3'd7: mode = MODE_FAST;
      default:    mode = MODE_RSVD;
    endcase
  end

  assign ocr_top = (wgm == 3'd5) || (wgm == 3'd7);
  assign top     = (ocr_top || wgm == 3'd2) ? ocr_buf[0] : MAX;

  // Count enable: one clk in N, aligned to the low prescaler bits all-ones.
  always_comb begin
    case (cs)
      3'd1:    en = 1'b1;
      3'd2:    en = &presc[2:0];
      3'd3:    en = &presc[5:0];
      3'd4:    en = &presc[7:0];
      3'd5:    en = &presc[9:0];
      default: en = 1'b0;
    endcase
  end

  assign step = en && !tcnt_we && (mode != MODE_RSVD);

  always_comb begin
    tcnt_nx = tcnt;
    dir_nx  = (mode == MODE_PHASE) ? dir : 1'b0;
    tov_set = 1'b0;
    wrap    = 1'b0;
    if (tcnt_we) begin
      tcnt_nx = tcnt_wdata;
    end else if (step) begin
      case (mode)
        MODE_NORMAL: begin
          tcnt_nx = tcnt + 1'b1;
          tov_set = (tcnt == MAX);
        end
        MODE_CTC: begin
          tcnt_nx = (tcnt == top) ? '0 : tcnt + 1'b1;
          tov_set = (tcnt == MAX);
        end
        MODE_FAST: begin
          // A counter written above TOP runs on to MAX and wraps there.
          wrap    = (tcnt == top) || (tcnt == MAX);
          tcnt_nx = wrap ? '0 : tcnt + 1'b1;
          tov_set = (tcnt == top);
        end
        MODE_PHASE: begin
          if (top == '0) begin
            tcnt_nx = '0;
            dir_nx  = 1'b0;
            tov_set = 1'b1;
          end else if (!dir) begin
            if ((tcnt == top) || (tcnt == MAX)) begin
              dir_nx  = 1'b1;
              tcnt_nx = tcnt - 1'b1;
            end else begin
              tcnt_nx = tcnt + 1'b1;
            end
          end else if (tcnt == '0) begin
            dir_nx  = 1'b0;
            tcnt_nx = tcnt + 1'b1;
            tov_set = 1'b1;
          end else begin
            tcnt_nx = tcnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Non-PWM modes track ocr directly; PWM modes reload only at TOP.
  always_comb begin
    case (mode)
      MODE_FAST:  buf_load = step && (tcnt == top);
      MODE_PHASE: buf_load = step && (tcnt == top) && !dir;
      default:    buf_load = 1'b1;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      match[i] = step && (tcnt == ocr_buf[i]);
    end
  end

  always_comb begin
    oc_nx = oc;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      case (mode)
        MODE_NORMAL, MODE_CTC: begin
          if (match[i]) begin
            case (com[2*i +: 2])
              2'd1:    oc_nx[i] = ~oc[i];
              2'd2:    oc_nx[i] = 1'b0;
              2'd3:    oc_nx[i] = 1'b1;
              default: ;
            endcase
          end
        end
        MODE_FAST: begin
          // The wrap action takes priority over a coincident match.
          case (com[2*i +: 2])
            2'd1: if (match[i] && i == 0 && ocr_top) oc_nx[i] = ~oc[i];
            2'd2: begin
              if (wrap)          oc_nx[i] = 1'b1;
              else if (match[i]) oc_nx[i] = 1'b0;
            end
            2'd3: begin
              if (wrap)          oc_nx[i] = 1'b0;
              else if (match[i]) oc_nx[i] = 1'b1;
            end
            default: ;
          endcase
        end
        MODE_PHASE: begin
          // Up-count match drives low (com 2), down-count match drives high.
          if (match[i]) begin
            case (com[2*i +: 2])
              2'd1:    if (i == 0 && ocr_top) oc_nx[i] = ~oc[i];
              2'd2:    oc_nx[i] = dir;
              2'd3:    oc_nx[i] = ~dir;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      tcnt  <= '0;
      dir   <= 1'b0;
      flags <= '0;
      oc    <= '0;
      tick  <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) ocr_buf[i] <= '0;
    end else begin
      presc <= presc + 1'b1;
      tick  <= en;
      tcnt  <= tcnt_nx;
      dir   <= dir_nx;
      flags <= (flags & ~flag_clr) | {match, tov_set};
      oc    <= oc_nx;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (buf_load) ocr_buf[i] <= ocr[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_timer_unit_multi.sv
module tb_timer_unit_multi;

  localparam int W    = 8;
  localparam int NC   = 2;
  localparam int PW   = 10;
  localparam int MAXV = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    cs;
  logic [2:0]    wgm;
  logic [3:0]    com;
  logic [15:0]   ocr;
  logic          tcnt_we;
  logic [7:0]    tcnt_wdata;
  logic [2:0]    flag_clr;
  logic [7:0]    tcnt;
  logic [2:0]    flags;
  logic [1:0]    oc;
  logic          dir;
  logic          tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int       m_presc;
  int       m_tcnt;
  bit       m_dir;
  bit [2:0] m_flags;
  bit [1:0] m_oc;
  bit       m_tick;
  int       m_buf [2];

  timer_unit_multi #(.WIDTH(W), .NUM_CH(NC), .PRESC_W(PW)) dut (
    .clk(clk), .reset(reset), .cs(cs), .wgm(wgm), .com(com), .ocr(ocr),
    .tcnt_we(tcnt_we), .tcnt_wdata(tcnt_wdata), .flag_clr(flag_clr),
    .tcnt(tcnt), .flags(flags), .oc(oc), .dir(dir), .tick(tick)
  );

  always #5 clk = ~clk;

  wire logic [14:0] dut_vec = {tcnt, flags, oc, dir, tick};

  function automatic logic [14:0] exp_vec();
    return {8'(m_tcnt), m_flags, m_oc, m_dir, m_tick};
  endfunction

  task automatic model_reset();
    m_presc = 0; m_tcnt = 0; m_dir = 0; m_flags = '0; m_oc = '0; m_tick = 0;
    m_buf[0] = 0; m_buf[1] = 0;
  endtask

  // One clock of the timer, straight from the mode rules, on integers.
  task automatic model_update();
    int div, top, nt, c;
    bit en, step, pcm, fpm, rsv, tov, wrap, nd;
    bit [1:0] mt, noc;
    bit [2:0] setv;
    case (cs)
      3'd1: div = 1;
      3'd2: div = 8;
      3'd3: div = 64;
      3'd4: div = 256;
      3'd5: div = 1024;
      default: div = 0;
    endcase
    en  = (div != 0) && ((m_presc % div) == div - 1);
    pcm = (wgm == 1) || (wgm == 5);
    fpm = (wgm == 3) || (wgm == 7);
    rsv = (wgm == 4) || (wgm == 6);
    top = (wgm == 2 || wgm == 5 || wgm == 7) ? m_buf[0] : MAXV;
    step = en && !tcnt_we && !rsv;
    nt = m_tcnt; nd = pcm ? m_dir : 1'b0; tov = 0;
    if (tcnt_we) nt = int'(tcnt_wdata);
    else if (step) begin
      if (wgm == 0) begin
        nt = (m_tcnt + 1) % 256; tov = (m_tcnt == MAXV);
      end else if (wgm == 2) begin
        nt = (m_tcnt == top) ? 0 : (m_tcnt + 1) % 256; tov = (m_tcnt == MAXV);
      end else if (fpm) begin
        nt = (m_tcnt == top) ? 0 : (m_tcnt + 1) % 256; tov = (m_tcnt == top);
      end else begin
        if (top == 0) begin
          nt = 0; nd = 0; tov = 1;
        end else if (!m_dir) begin
          if (m_tcnt == top || m_tcnt == MAXV) begin nd = 1; nt = m_tcnt - 1; end
          else nt = m_tcnt + 1;
        end else begin
          if (m_tcnt == 0) begin nd = 0; nt = 1; tov = 1; end
          else nt = m_tcnt - 1;
        end
      end
    end
    wrap = fpm && step && (nt == 0);
    for (int i = 0; i < 2; i++) mt[i] = step && (m_tcnt == m_buf[i]);
    noc = m_oc;
    for (int i = 0; i < 2; i++) begin
      c = (int'(com) >> (2 * i)) & 3;
      if (wgm == 0 || wgm == 2) begin
        if (mt[i] && c == 1) noc[i] = ~m_oc[i];
        if (mt[i] && c == 2) noc[i] = 0;
        if (mt[i] && c == 3) noc[i] = 1;
      end else if (fpm) begin
        if (c == 2) noc[i] = wrap ? 1'b1 : (mt[i] ? 1'b0 : m_oc[i]);
        if (c == 3) noc[i] = wrap ? 1'b0 : (mt[i] ? 1'b1 : m_oc[i]);
        if (c == 1 && mt[i] && i == 0 && wgm == 7) noc[i] = ~m_oc[i];
      end else if (pcm) begin
        if (c == 2 && mt[i]) noc[i] = m_dir;
        if (c == 3 && mt[i]) noc[i] = !m_dir;
        if (c == 1 && mt[i] && i == 0 && wgm == 5) noc[i] = ~m_oc[i];
      end
    end
    setv = {mt, tov};
    if (!(pcm || fpm)) begin
      m_buf[0] = int'(ocr[7:0]); m_buf[1] = int'(ocr[15:8]);
    end else if (step && m_tcnt == top && (fpm || !m_dir)) begin
      m_buf[0] = int'(ocr[7:0]); m_buf[1] = int'(ocr[15:8]);
    end
    m_flags = (m_flags & ~flag_clr) | setv;
    m_oc    = noc;
    m_tcnt  = nt;
    m_dir   = nd;
    m_tick  = en;
    m_presc = (m_presc + 1) % 1024;
  endtask

  task automatic cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [2:0] wg, input logic [7:0] wdata,
                       input logic [15:0] o, input logic [3:0] cm, input logic [2:0] clr);
    cs = 3'd0; wgm = wg; tcnt_we = 1'b1; tcnt_wdata = wdata;
    ocr = o; com = cm; flag_clr = clr;
    cycle();
    tcnt_we = 1'b0; flag_clr = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b0; cs = 0; wgm = 0; com = 0; ocr = 0;
    tcnt_we = 0; tcnt_wdata = 0; flag_clr = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    if (tcnt !== 8'h00) begin n_fail++; $display("FAIL reset_tcnt got=%h exp=00", tcnt); end
    n_checks++;
    if (flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", flags); end
    n_checks++;
    if (oc !== 2'b00) begin n_fail++; $display("FAIL reset_oc got=%b exp=00", oc); end
    n_checks++;
    if (dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir got=%b exp=0", dir); end
    n_checks++;
    if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", tick); end
    n_checks++;
    reset = 1'b1;
  endtask

  task automatic test_normal();
    int tov_rises, toggles;
    logic prev_oc0, prev_tov;
    setup(3'd0, 8'h00, 16'h8010, 4'b0001, 3'b111);
    cs = 3'd1;
    tov_rises = 0; toggles = 0; prev_oc0 = oc[0]; prev_tov = flags[0];
    for (int k = 0; k < 256; k++) begin
      cycle();
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL normal_model got=%h exp=%h", dut_vec, exp_vec()); end
      n_checks++;
      if (flags[0] && !prev_tov) tov_rises++;
      if (oc[0] !== prev_oc0) begin
        toggles++;
        if (tcnt !== 8'h11) begin n_fail++; $display("FAIL normal_toggle_at got=%h exp=11", tcnt); end
        n_checks++;
      end
      prev_oc0 = oc[0]; prev_tov = flags[0];
    end
    if (tov_rises !== 1) begin n_fail++; $display("FAIL normal_tov_count got=%0d exp=1", tov_rises); end
    n_checks++;
    if (toggles !== 1) begin n_fail++; $display("FAIL normal_oc_toggles got=%0d exp=1", toggles); end
    n_checks++;
    if (tcnt !== 8'h00) begin n_fail++; $display("FAIL normal_wrap got=%h exp=00", tcnt); end
    n_checks++;
  endtask

  task automatic test_ctc();
    int changes, maxv;
    logic [7:0] prev;
    setup(3'd2, 8'h00, 16'h8004, 4'b0000, 3'b111);
    cs = 3'd2;
    changes = 0; maxv = 0; prev = tcnt;
    for (int k = 0; k < 160; k++) begin
      cycle();
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL ctc_model got=%h exp=%h", dut_vec, exp_vec()); end
      n_checks++;
      if (tcnt !== prev) begin
        changes++;
        if (tcnt !== ((prev == 8'd4) ? 8'd0 : prev + 8'd1)) begin
          n_fail++; $display("FAIL ctc_sequence got=%h prev=%h", tcnt, prev);
        end
        n_checks++;
      end
      if (int'(tcnt) > maxv) maxv = int'(tcnt);
      prev = tcnt;
    end
    if (changes !== 20) begin n_fail++; $display("FAIL ctc_step_count got=%0d exp=20", changes); end
    n_checks++;
    if (maxv !== 4) begin n_fail++; $display("FAIL ctc_max got=%0d exp=4", maxv); end
    n_checks++;
    if (flags[0] !== 1'b0) begin n_fail++; $display("FAIL ctc_no_tov got=%b exp=0", flags[0]); end
    n_checks++;
    if (flags[1] !== 1'b1) begin n_fail++; $display("FAIL ctc_ocf0 got=%b exp=1", flags[1]); end
    n_checks++;
  endtask

  task automatic test_fast_pwm();
    setup(3'd0, 8'h00, 16'h8040, 4'b0010, 3'b111);
    cs = 3'd1; wgm = 3'd3;
    for (int k = 0; k < 32; k++) begin
      cycle();
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL fast_model got=%h exp=%h", dut_vec, exp_vec()); end
      n_checks++;
    end
    ocr = 16'h8080;
    for (int k = 0; k < 48; k++) begin
      cycle();
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL fast_model got=%h exp=%h", dut_vec, exp_vec()); end
      n_checks++;
    end
    if ({tcnt, oc[0]} !== {8'h50, 1'b0}) begin
      n_fail++; $display("FAIL fast_old_ocr got tcnt=%h oc=%b exp tcnt=50 oc=0", tcnt, oc[0]);
    end
    n_checks++;
    for (int k = 0; k < 256; k++) begin
      cycle();
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL fast_model got=%h exp=%h", dut_vec, exp_vec()); end
      n_checks++;
    end
    if ({tcnt, oc[0]} !== {8'h50, 1'b1}) begin
      n_fail++; $display("FAIL fast_new_ocr got tcnt=%h oc=%b exp tcnt=50 oc=1", tcnt, oc[0]);
    end
    n_checks++;
    for (int k = 0; k < 49; k++) cycle();
    if ({tcnt, oc[0]} !== {8'h81, 1'b0}) begin
      n_fail++; $display("FAIL fast_new_clear got tcnt=%h oc=%b exp tcnt=81 oc=0", tcnt, oc[0]);
    end
    n_checks++;
  endtask

  task automatic test_phase_correct();
    int dir_changes, maxv, first_tov;
    logic prev_dir;
    setup(3'd0, 8'h00, 16'h040A, 4'b1000, 3'b111);
    cs = 3'd1; wgm = 3'd5;
    dir_changes = 0; maxv = 0; first_tov = -1; prev_dir = dir;
    for (int k = 1; k <= 80; k++) begin
      cycle();
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL phase_model got=%h exp=%h", dut_vec, exp_vec()); end
      n_checks++;
      if (dir !== prev_dir) dir_changes++;
      prev_dir = dir;
      if (int'(tcnt) > maxv) maxv = int'(tcnt);
      if (flags[0] && first_tov < 0) first_tov = k;
      if (tcnt == 8'd5 && !dir) begin
        if (oc[1] !== 1'b0) begin n_fail++; $display("FAIL phase_oc1_up got=%b exp=0", oc[1]); end
        n_checks++;
      end
      if (tcnt == 8'd3 && dir) begin
        if (oc[1] !== 1'b1) begin n_fail++; $display("FAIL phase_oc1_down got=%b exp=1", oc[1]); end
        n_checks++;
      end
    end
    if (dir_changes !== 7) begin n_fail++; $display("FAIL phase_dir_changes got=%0d exp=7", dir_changes); end
    n_checks++;
    if (maxv !== 10) begin n_fail++; $display("FAIL phase_max got=%0d exp=10", maxv); end
    n_checks++;
    if (first_tov !== 21) begin n_fail++; $display("FAIL phase_first_tov got=%0d exp=21", first_tov); end
    n_checks++;
  endtask

  task automatic test_write_override();
    setup(3'd0, 8'h20, 16'h8020, 4'b0000, 3'b111);
    cs = 3'd1; tcnt_we = 1'b1; tcnt_wdata = 8'h20;
    cycle();
    if (tcnt !== 8'h20) begin n_fail++; $display("FAIL we_tcnt got=%h exp=20", tcnt); end
    n_checks++;
    if (flags[1] !== 1'b0) begin n_fail++; $display("FAIL we_no_ocf0 got=%b exp=0", flags[1]); end
    n_checks++;
    tcnt_wdata = 8'hFF;
    cycle();
    tcnt_we = 1'b0; flag_clr = 3'b001;
    cycle();
    flag_clr = 3'b000;
    if (flags[0] !== 1'b1) begin n_fail++; $display("FAIL tov_set_wins got=%b exp=1", flags[0]); end
    n_checks++;
    if (tcnt !== 8'h00) begin n_fail++; $display("FAIL we_wrap got=%h exp=00", tcnt); end
    n_checks++;
    if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL we_model got=%h exp=%h", dut_vec, exp_vec()); end
    n_checks++;
  endtask

  task automatic test_random();
    wgm = 3'($urandom_range(0, 7));
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 63) == 0) wgm = 3'($urandom_range(0, 7));
      cs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 2));
      if ($urandom_range(0, 15) == 0) begin
        ocr[15:8] = 8'($urandom_range(0, 255));
        ocr[7:0]  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 31) == 0) com = 4'($urandom);
      tcnt_we    = ($urandom_range(0, 15) == 0);
      tcnt_wdata = 8'($urandom);
      flag_clr   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      cycle();
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_model k=%0d wgm=%0d got=%h exp=%h", k, wgm, dut_vec, exp_vec());
      end
      n_checks++;
    end
    tcnt_we = 1'b0; flag_clr = 3'b000;
  endtask

  task automatic test_reset_mid();
    setup(3'd0, 8'h00, 16'h8010, 4'b0000, 3'b111);
    cs = 3'd5;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL rmid_model got=%h exp=%h", dut_vec, exp_vec()); end
      n_checks++;
    end
    ocr = 16'h8010; com = 4'b0011; flag_clr = 3'b000;
    #2 reset = 1'b0;
    #1;
    if (dut_vec !== 15'h0) begin n_fail++; $display("FAIL rmid_async got=%h exp=0000", dut_vec); end
    n_checks++;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 1023; k++) begin
      cycle();
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL rmid_model got=%h exp=%h", dut_vec, exp_vec()); end
      n_checks++;
    end
    if ({tcnt, tick} !== {8'h00, 1'b0}) begin
      n_fail++; $display("FAIL rmid_before_en got tcnt=%h tick=%b exp tcnt=00 tick=0", tcnt, tick);
    end
    n_checks++;
    cycle();
    if ({tcnt, tick} !== {8'h01, 1'b1}) begin
      n_fail++; $display("FAIL rmid_first_en got tcnt=%h tick=%b exp tcnt=01 tick=1", tcnt, tick);
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_ctc();
    test_fast_pwm();
    test_phase_correct();
    test_write_override();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
